// File: rtl/display_mux.sv
// Eight-digit multiplexed seven-segment driver for the calculator status display.
// Holds a digit buffer, scans one digit per slot and decodes ready/busy/error views.
module display_mux #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2,
  parameter int LZB       = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] pos,
  input  logic [3:0] data,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_O     = 7'b0100011;

  logic [3:0]    digits_reg [8];
  logic          err_prev_reg;
  logic [PW-1:0] presc_reg;
  logic [2:0]    idx_reg;
  logic [7:0]    an_reg;
  logic [6:0]    seg_reg;

  logic       is_err;
  logic       is_busy;
  logic [7:0] sig_digit;
  logic [7:0] lead_zero;
  logic [3:0] cur_digit;
  logic       zero_blank;
  logic [7:0] an_next;
  logic [6:0] seg_next;

  assign is_err  = (status == 2'b00) || (status == 2'b11);
  assign is_busy = (status == 2'b10);

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = SEG_BLANK;
    endcase
  endfunction

  // A digit is significant only if it renders as 1..9; lead_zero[i] means nothing significant at i or above.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sig
      assign sig_digit[gi] = (digits_reg[gi] != 4'd0) && (digits_reg[gi] < 4'd10);
    end
    for (genvar gi = 1; gi < 8; gi++) begin : g_lead
      assign lead_zero[gi] = ~|sig_digit[7:gi];
    end
  endgenerate
  assign lead_zero[0] = 1'b0;

  // The cycle the buffer is being cleared, show the post-clear contents rather than stale digits.
  assign cur_digit  = err_prev_reg ? 4'd0 : digits_reg[idx_reg];
  assign zero_blank = (LZB != 0) && (idx_reg != 3'd0) && (err_prev_reg || lead_zero[idx_reg]);

  always_comb begin
    an_next  = (presc_reg < BLANK_END) ? 8'hFF : ~(8'd1 << idx_reg);
    seg_next = SEG_BLANK;
    if (is_err) begin
      case (idx_reg)
        3'd3:       seg_next = SEG_E;
        3'd2, 3'd1: seg_next = SEG_R;
        3'd0:       seg_next = SEG_O;
        default:    seg_next = SEG_BLANK;
      endcase
    end else if (is_busy) begin
      seg_next = SEG_DASH;
    end else if (!zero_blank) begin
      seg_next = dec7(cur_digit);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) digits_reg[i] <= 4'd0;
      err_prev_reg <= 1'b0;
    end else begin
      err_prev_reg <= is_err;
      if (!is_err) begin
        if (err_prev_reg) begin
          for (int i = 0; i < 8; i++) digits_reg[i] <= 4'd0;
        end else if (!pos[3]) begin
          digits_reg[pos[2:0]] <= data;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_reg <= '0;
      idx_reg   <= 3'd0;
      an_reg    <= 8'hFF;
      seg_reg   <= 7'h7F;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      if (presc_reg == PRESC_MAX) begin
        presc_reg <= '0;
        idx_reg   <= idx_reg + 3'd1;
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_display_mux.sv
// Directed bench for display_mux with a short scan period (4 cycles/slot, 1 blank cycle).
module tb_display_mux;

  logic       clock;
  logic       reset;
  logic [1:0] status;
  logic [3:0] pos;
  logic [3:0] data;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests_run = 0;
  int failures  = 0;

  localparam logic [6:0] S_BL = 7'b1111111;
  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] S_E  = 7'b0000110;
  localparam logic [6:0] S_R  = 7'b0101111;
  localparam logic [6:0] S_O  = 7'b0100011;

  display_mux #(.SCAN_DIV(4), .BLANK_CYC(1), .LZB(1)) dut (
    .clock  (clock),
    .reset  (reset),
    .status (status),
    .pos    (pos),
    .data   (data),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic wr(input logic [3:0] p, input logic [3:0] d);
    pos  = p;
    data = d;
    @(negedge clock);
  endtask

  // Observe 32 cycles (eight full slots) and compare each digit's segments; exp packed {d7..d0}.
  task automatic frame(input string tag, input logic [55:0] exp);
    logic [6:0] cap [8];
    logic [7:0] seen;
    int         nblank;
    seen   = 8'h00;
    nblank = 0;
    repeat (2) @(negedge clock);
    for (int c = 0; c < 32; c++) begin
      @(negedge clock);
      if (an == 8'hFF) nblank++;
      else begin
        for (int d = 0; d < 8; d++) begin
          if (an == 8'(~(8'd1 << d))) begin
            seen[d] = 1'b1;
            cap[d]  = seg;
          end
        end
      end
    end
    check({tag, " blank_cycles"}, nblank, 8);
    check({tag, " slots_seen"}, {24'd0, seen}, 32'hFF);
    for (int d = 0; d < 8; d++)
      check($sformatf("%s d%0d", tag, d), {25'd0, cap[d]}, {25'd0, exp[d*7 +: 7]});
  endtask

  initial begin
    reset  = 1'b0;
    status = 2'b01;
    pos    = 4'd0;
    data   = 4'd0;
    repeat (3) @(negedge clock);
    check("reset an", an, 8'hFF);
    check("reset seg", seg, 7'h7F);
    check("reset dp", dp, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    check("start blank an", an, 8'hFF);
    @(negedge clock);
    check("start slot0 an", an, 8'hFE);
    check("start slot0 seg", seg, S0);
    frame("zero", {{7{S_BL}}, S0});

    wr(4'd2, 4'd7);
    wr(4'd0, 4'd3);
    frame("703", {{5{S_BL}}, S7, S0, S3});

    // Busy: dash on every lit slot from the very next edge; no writes issued meanwhile.
    pos    = 4'd9;
    status = 2'b10;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (c == 0 || an != 8'hFF) check($sformatf("busy c%0d", c), seg, DASH);
    end
    status = 2'b01;
    frame("after busy", {{5{S_BL}}, S7, S0, S3});

    wr(4'd0, 4'd5);
    status = 2'b00;
    pos    = 4'd0;
    data   = 4'd9;
    @(negedge clock);
    check("erro first seg is error view", (seg == S_E || seg == S_R || seg == S_O || seg == S_BL), 1'b1);
    frame("erro", {{4{S_BL}}, S_E, S_R, S_R, S_O});
    status = 2'b01;
    @(negedge clock);
    pos = 4'd9;
    frame("cleared", {{7{S_BL}}, S0});

    wr(4'd1, 4'd8);
    wr(4'd3, 4'd12);
    wr(4'd9, 4'd4);
    frame("pos9 ignored", {{6{S_BL}}, S8, S0});

    // Asynchronous reset in the middle of slot 5.
    begin
      bit found;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
        @(negedge clock);
        if (an == 8'b1101_1111) found = 1'b1;
      end
      check("reach slot5", found, 1'b1);
    end
    #2 reset = 1'b0;
    #1;
    check("async rst an", an, 8'hFF);
    check("async rst seg", seg, 7'h7F);
    @(negedge clock);
    check("held rst an", an, 8'hFF);
    reset = 1'b1;
    @(negedge clock);
    check("restart blank an", an, 8'hFF);
    @(negedge clock);
    check("restart slot0 an", an, 8'hFE);
    check("restart slot0 seg", seg, S0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles per digit slot (legal range 2..2^20).
REQ-002 SHALL have parameter BLANK_CYC, default 2, meaning cycles at the start of each slot with all anodes off; SHALL be less than SCAN_DIV.
REQ-003 SHALL have parameter LZB, default 1, meaning leading-zero blanking is enabled when 1.
REQ-004 clock  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 status  input  2  calculator state: 00 ERRO, 01 PRONTA, 10 OCUPADA; 11 is treated as ERRO.
REQ-007 pos  input  4  digit position to write, 0 = rightmost.
REQ-008 data  input  4  digit value to write.
REQ-009 an  output  8  active-low anode enables, bit i drives digit i.
REQ-010 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  active-low decimal point.

Function
REQ-012 SHALL hold an 8 x 4-bit digit buffer.
REQ-013 Buffer write: each cycle with status = PRONTA or OCUPADA and pos <= 7, buf[pos] SHALL be loaded with data; pos 8..15 SHALL be ignored.
REQ-014 Buffer SHALL be frozen while status is ERRO/11.
REQ-015 On the first cycle status leaves ERRO/11, the buffer SHALL clear to all zeros, and that cycle's write SHALL be suppressed.
REQ-016 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; on wrap, 3-bit scan index SHALL advance 0->1->...->7->0.
REQ-017 an and seg SHALL be registered outputs computed from the current scan index, prescaler value and buffer/status.
REQ-018 Latency: a buffer write at edge N SHALL be visible on seg at edge N+1, provided the index addresses that digit.
REQ-019 While prescaler < BLANK_CYC, an SHALL be 8'hFF; otherwise an SHALL be ~(1 << index).
REQ-020 Decode, PRONTA, seg values:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - values 10..15 = blank 1111111
REQ-021 With LZB=1, digit i>=1 SHALL be blank when buf[j] is 0 or >=10 for every j>=i; digit 0 SHALL never be zero-blanked.
REQ-022 OCUPADA SHALL show dash 0111111 on every digit, independent of buffer contents.
REQ-023 ERRO/11 SHALL show "Erro" on digits 3..0 and blank on digits 7..4. Codes: E=0000110, r=0101111, o=0100011.
REQ-024 A status change SHALL affect seg at the next edge, without waiting for slot end.
REQ-025 dp SHALL be constant 1.
REQ-026 Simultaneous prescaler wrap and buffer write: the write and the index advance SHALL both take effect on the same edge.

Reset
REQ-027 Asserting reset SHALL immediately apply, regardless of clock, even mid-slot:
  - buffer all zeros, prescaler 0, index 0
  - an=8'hFF, seg=7'h7F, dp=1
REQ-028 After deassertion, the first slot SHALL be index 0, with anodes off for BLANK_CYC cycles.

Verification (SCAN_DIV=4, BLANK_CYC=1, LZB=1)
REQ-029 Reset, then status=01, pos=0, data=0 held; sample over 32 cycles -> an=11111110 in slot 0 after 1 blank cycle, seg=1000000; digits 1..7 seg=1111111.
REQ-030 Write pos=2 data=7, then pos=0 data=3 -> slot 2 seg=1111000, slot 1 seg=1000000, slot 0 seg=0110000, slots 3..7 blank.
REQ-031 status=10 for 10 cycles -> every non-blank slot seg=0111111; buffer unchanged when returning to 01.
REQ-032 With buffer holding 5 at pos 0, status=00 with pos=0 data=9 -> digits 3..0 show E,r,r,o. Return to 01 -> buffer all zero, digit 0 shows 0.
REQ-033 Write pos=9 data=4 -> buffer unchanged; display identical to before.
REQ-034 Assert reset mid-slot at index 5 -> an=FF and seg=7F immediately; after release, index 0 restarts with a blank cycle first.
